// File: rtl/dac7611_rx_if.sv
// ---------------------------------------------------------------------------
// dac7611_rx_if
// Carries the 4-wire DAC7611 serial bundle between a driver and the receiver.
//   dac_signals_15[3] : CLK (serial clock)
//   dac_signals_15[2] : SDI (serial data, MSB first)
//   dac_signals_15[1] : LD  (load, word transferred on falling edge)
//   dac_signals_15[0] : CLR (clear, active-low)
// master drives the bundle; slave observes it.
// ---------------------------------------------------------------------------
interface dac7611_rx_if;
    logic [3:0] dac_signals_15;

    modport master (output dac_signals_15);
    modport slave  (input  dac_signals_15);
endinterface

// File: rtl/dac7611_rx.sv
// ---------------------------------------------------------------------------
// dac7611_rx
// Recovers 12-bit MSB-first words from the DAC7611 serial bundle. Used as a
// loopback checker for the on-chip driver and as a DAC stand-in in benches.
//
// Ports
//   clk         system clock (same domain as the driver)
//   reset       asynchronous, active-low reset
//   dac         slave side of the serial bundle {CLK, SDI, LD, CLR}
//   dac_code    last successfully loaded word
//   code_valid  one-cycle pulse when dac_code is loaded from a frame
//   frame_err   one-cycle pulse on LD fall with a wrong bit count
//   clr_active  high while the receiver is held in CLEAR
//   bit_cnt     CLK rises accepted in the current frame, saturating at 15
//
// State table
//   ST_SHIFT | collecting bits on CLK rises, waiting for LD fall
//   ST_HOLD  | frame closed; CLK ignored until LD returns high
//   ST_CLEAR | CLR asserted; code, shift register and count forced to 0
// ---------------------------------------------------------------------------
module dac7611_rx #(
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    dac7611_rx_if.slave          dac,
    output logic [DATA_BITS-1:0] dac_code,
    output logic                 code_valid,
    output logic                 frame_err,
    output logic                 clr_active,
    output logic [3:0]           bit_cnt
);

    typedef enum logic [1:0] {
        ST_SHIFT = 2'd0,
        ST_HOLD  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Idle line levels {CLK=1, SDI=0, LD=1, CLR=1}; resetting the pipeline to
    // these keeps reset release from looking like an edge.
    localparam logic [3:0] SYNC_IDLE = 4'b1011;
    localparam logic [3:0] FULL_CNT  = 4'(DATA_BITS);

    state_t state, state_nxt;

    logic [3:0]           sync1, sync2;
    logic [1:0]           sync3;          // {CLK, LD} delayed once more for edges
    logic [DATA_BITS-1:0] shift_reg, shift_nxt, shifted;
    logic [DATA_BITS-1:0] code_nxt;
    logic [3:0]           cnt_nxt, cnt_inc;
    logic                 valid_nxt, err_nxt;

    logic clk_rise, ld_fall, ld_rise, sdi, clr_b, ld_lvl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
            sync3 <= 2'b11;
        end else begin
            sync1 <= dac.dac_signals_15;
            sync2 <= sync1;
            sync3 <= {sync2[3], sync2[1]};
        end
    end

    assign clk_rise = sync2[3] & ~sync3[1];
    assign ld_fall  = ~sync2[1] & sync3[0];
    assign ld_rise  = sync2[1] & ~sync3[0];
    assign sdi      = sync2[2];
    assign ld_lvl   = sync2[1];
    assign clr_b    = sync2[0];

    assign shifted  = {shift_reg[DATA_BITS-2:0], sdi};
    assign cnt_inc  = (bit_cnt == 4'hF) ? bit_cnt : bit_cnt + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_SHIFT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        code_nxt  = dac_code;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;

        if (!clr_b) begin
            // CLR outranks everything, including an LD fall in the same cycle.
            state_nxt = ST_CLEAR;
            shift_nxt = '0;
            cnt_nxt   = '0;
            code_nxt  = '0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (clk_rise) begin
                        shift_nxt = shifted;
                        cnt_nxt   = cnt_inc;
                    end
                    // The compare sees the post-shift values, so a CLK rise and
                    // LD fall landing together still close a complete frame.
                    if (ld_fall) begin
                        if (cnt_nxt == FULL_CNT) begin
                            code_nxt  = shift_nxt;
                            valid_nxt = 1'b1;
                        end else begin
                            err_nxt   = 1'b1;
                        end
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ld_rise) begin
                        shift_nxt = '0;
                        cnt_nxt   = '0;
                        state_nxt = ST_SHIFT;
                    end
                end
                ST_CLEAR: begin
                    state_nxt = ld_lvl ? ST_SHIFT : ST_HOLD;
                end
                default: begin
                    state_nxt = ST_SHIFT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            dac_code   <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            shift_reg  <= shift_nxt;
            bit_cnt    <= cnt_nxt;
            dac_code   <= code_nxt;
            code_valid <= valid_nxt;
            frame_err  <= err_nxt;
        end
    end

    assign clr_active = (state == ST_CLEAR);

endmodule

// File: tb/tb_dac7611_rx.sv
// ---------------------------------------------------------------------------
// tb_dac7611_rx
// Directed bench for dac7611_rx: drives the serial bundle the way the DAC7611
// driver does (2 clk low / 2 clk high per bit) and checks recovered words,
// error pulses and CLR/reset behaviour against hand-computed values.
// ---------------------------------------------------------------------------
module tb_dac7611_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] dac_code;
    logic        code_valid, frame_err, clr_active;
    logic [3:0]  bit_cnt;

    logic l_clk = 1'b1, l_sdi = 1'b0, l_ld = 1'b1, l_clr = 1'b1;

    int errors = 0;
    int checks = 0;

    int n_valid = 0, n_err = 0, n_clr = 0, n_both = 0;

    always #5 clk = ~clk;

    dac7611_rx_if dif ();
    assign dif.dac_signals_15 = {l_clk, l_sdi, l_ld, l_clr};

    dac7611_rx #(.DATA_BITS(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .dac        (dif),
        .dac_code   (dac_code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .clr_active (clr_active),
        .bit_cnt    (bit_cnt)
    );

    always @(negedge clk) begin
        if (code_valid === 1'b1) n_valid++;
        if (frame_err === 1'b1)  n_err++;
        if (clr_active === 1'b1) n_clr++;
        if (code_valid === 1'b1 && frame_err === 1'b1) n_both++;
    end

    // ---- stimulus helpers (no checking inside) ----
    task automatic send_bits(input logic [15:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            l_clk = 1'b0;
            l_sdi = data[i];
            repeat (2) @(negedge clk);
            l_clk = 1'b1;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic ld_pulse();
        @(negedge clk);
        l_ld = 1'b0;
        repeat (2) @(negedge clk);
        l_ld = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // ---- tests ----
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dac_code !== 12'h000) begin errors++; $display("FAIL reset_code got=%h exp=000", dac_code); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", code_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        checks++; if (clr_active !== 1'b0) begin errors++; $display("FAIL reset_clr got=%b exp=0", clr_active); end
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bit_cnt); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bit_cnt !== 4'd0 || code_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL release_quiet cnt=%0d valid=%b err=%b exp 0/0/0", bit_cnt, code_valid, frame_err);
        end
    endtask

    task automatic test_driver_frame();
        int c0, v0, e0;
        c0 = n_clr; v0 = n_valid; e0 = n_err;
        @(negedge clk); l_clr = 1'b0;
        repeat (4) @(negedge clk);
        l_clr = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (n_clr - c0 < 1) begin errors++; $display("FAIL drv_clr_pulse got=%0d cycles exp>=1", n_clr - c0); end
        checks++; if (clr_active !== 1'b0) begin errors++; $display("FAIL drv_clr_exit got=%b exp=0", clr_active); end
        send_bits(16'h0555, 12);
        checks++; if (bit_cnt !== 4'd12) begin errors++; $display("FAIL drv_cnt got=%0d exp=12", bit_cnt); end
        ld_pulse();
        checks++; if (dac_code !== 12'h555) begin errors++; $display("FAIL drv_code got=%h exp=555", dac_code); end
        checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL drv_valid got=%0d exp=1", n_valid - v0); end
        checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL drv_err got=%0d exp=0", n_err - e0); end
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL drv_cnt_cleared got=%0d exp=0", bit_cnt); end
    endtask

    task automatic test_short_frame();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_bits(16'h07FF, 11);
        checks++; if (bit_cnt !== 4'd11) begin errors++; $display("FAIL short_cnt got=%0d exp=11", bit_cnt); end
        ld_pulse();
        checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL short_err got=%0d exp=1", n_err - e0); end
        checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL short_valid got=%0d exp=0", n_valid - v0); end
        checks++; if (dac_code !== 12'h555) begin errors++; $display("FAIL short_code got=%h exp=555", dac_code); end
    endtask

    task automatic test_overrun();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_bits(16'h3FFF, 14);
        checks++; if (bit_cnt !== 4'd14) begin errors++; $display("FAIL over_cnt got=%0d exp=14", bit_cnt); end
        ld_pulse();
        checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL over_err got=%0d exp=1", n_err - e0); end
        checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL over_valid got=%0d exp=0", n_valid - v0); end
        checks++; if (dac_code !== 12'h555) begin errors++; $display("FAIL over_code got=%h exp=555", dac_code); end
    endtask

    task automatic test_mid_frame_clr();
        int v0;
        v0 = n_valid;
        send_bits(16'h0ABC, 12);
        ld_pulse();
        checks++; if (dac_code !== 12'hABC) begin errors++; $display("FAIL mclr_first got=%h exp=ABC", dac_code); end
        checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL mclr_first_valid got=%0d exp=1", n_valid - v0); end
        send_bits(16'h002A, 6);
        checks++; if (bit_cnt !== 4'd6) begin errors++; $display("FAIL mclr_partial got=%0d exp=6", bit_cnt); end
        @(negedge clk); l_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (clr_active !== 1'b1) begin errors++; $display("FAIL mclr_active got=%b exp=1", clr_active); end
        checks++; if (dac_code !== 12'h000) begin errors++; $display("FAIL mclr_code got=%h exp=000", dac_code); end
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL mclr_cnt got=%0d exp=0", bit_cnt); end
        @(negedge clk); l_clr = 1'b1;
        repeat (6) @(negedge clk);
        v0 = n_valid;
        send_bits(16'h0123, 12);
        ld_pulse();
        checks++; if (dac_code !== 12'h123) begin errors++; $display("FAIL mclr_code2 got=%h exp=123", dac_code); end
        checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL mclr_valid2 got=%0d exp=1", n_valid - v0); end
    endtask

    task automatic test_clr_during_ld();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_bits(16'h03C5, 12);
        @(negedge clk);
        l_ld  = 1'b0;
        l_clr = 1'b0;
        repeat (2) @(negedge clk);
        l_ld = 1'b1;
        repeat (2) @(negedge clk);
        l_clr = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL cld_valid got=%0d exp=0", n_valid - v0); end
        checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL cld_err got=%0d exp=0", n_err - e0); end
        checks++; if (dac_code !== 12'h000) begin errors++; $display("FAIL cld_code got=%h exp=000", dac_code); end
    endtask

    task automatic test_async_reset();
        int v0, e0;
        send_bits(16'h0015, 5);
        checks++; if (bit_cnt !== 4'd5) begin errors++; $display("FAIL ars_partial got=%0d exp=5", bit_cnt); end
        #3 reset = 1'b0;
        #1;
        checks++; if (bit_cnt !== 4'd0 || dac_code !== 12'h000 || code_valid !== 1'b0 || frame_err !== 1'b0 || clr_active !== 1'b0) begin
            errors++; $display("FAIL ars_in_reset cnt=%0d code=%h valid=%b err=%b clr=%b exp all 0", bit_cnt, dac_code, code_valid, frame_err, clr_active);
        end
        @(negedge clk);
        l_clk = 1'b1; l_sdi = 1'b0; l_ld = 1'b1; l_clr = 1'b1;
        repeat (3) @(negedge clk);
        v0 = n_valid; e0 = n_err;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send_bits(16'h0FFF, 12);
        ld_pulse();
        checks++; if (dac_code !== 12'hFFF) begin errors++; $display("FAIL ars_code got=%h exp=FFF", dac_code); end
        checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL ars_valid got=%0d exp=1", n_valid - v0); end
        checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL ars_err got=%0d exp=0", n_err - e0); end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = n_valid;
        send_bits(16'h00F0, 12);
        ld_pulse();
        checks++; if (dac_code !== 12'h0F0) begin errors++; $display("FAIL b2b_first got=%h exp=0F0", dac_code); end
        send_bits(16'h0F0F, 12);
        ld_pulse();
        checks++; if (dac_code !== 12'hF0F) begin errors++; $display("FAIL b2b_second got=%h exp=F0F", dac_code); end
        checks++; if (n_valid - v0 != 2) begin errors++; $display("FAIL b2b_valid got=%0d exp=2", n_valid - v0); end
        checks++; if (n_both != 0) begin errors++; $display("FAIL exclusive_pulses got=%0d exp=0", n_both); end
    endtask

    initial begin
        test_reset();
        test_driver_frame();
        test_short_frame();
        test_overrun();
        test_mid_frame_clr();
        test_clr_during_ld();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
